// File: rtl/pattern_gen.sv
// rtl/pattern_gen.sv - 240p test-pattern generator: pixel enable, NTSC/PAL timing, four RGB patterns
module pattern_gen #(
  parameter int CE_DIV    = 4,
  parameter int COLOR_W   = 8,
  parameter int H_ACTIVE  = 320,
  parameter int H_FP      = 15,
  parameter int H_SYNC    = 32,
  parameter int H_BP      = 33,
  parameter int V_ACTIVE  = 240,
  parameter int V_FP      = 4,
  parameter int V_SYNC    = 3,
  parameter int V_BP_NTSC = 15,
  parameter int V_BP_PAL  = 65
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pal,
  input  logic [1:0]         pattern_sel,
  output logic               ce_pix,
  output logic               hblank,
  output logic               hsync,
  output logic               vblank,
  output logic               vsync,
  output logic               frame_start,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b
);
  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL_NTSC = V_ACTIVE + V_FP + V_SYNC + V_BP_NTSC;
  localparam int V_TOTAL_PAL  = V_ACTIVE + V_FP + V_SYNC + V_BP_PAL;
  localparam int V_TOTAL_MAX  = (V_TOTAL_PAL > V_TOTAL_NTSC) ? V_TOTAL_PAL : V_TOTAL_NTSC;
  localparam int HC_W         = $clog2(H_TOTAL);
  localparam int VC_W         = $clog2(V_TOTAL_MAX);
  localparam int DIV_W        = $clog2(CE_DIV);
  localparam int FULL         = (1 << COLOR_W) - 1;
  localparam int MID          = 1 << (COLOR_W - 1);
  localparam int GRID_BG      = (FULL * 30 + 50) / 100;
  localparam int BOX_X0       = H_ACTIVE / 2 - 50;
  localparam int BOX_X1       = BOX_X0 + 99;
  localparam int BOX_Y0       = V_ACTIVE / 2 - 50;
  localparam int BOX_Y1       = BOX_Y0 + 99;
  localparam int SAFE_X0      = 32;
  localparam int SAFE_X1      = H_ACTIVE - 1 - 32;
  localparam int SAFE_Y0      = 25;
  localparam int SAFE_Y1      = V_ACTIVE - 1 - 25;

  logic [DIV_W-1:0]   div;
  logic [HC_W-1:0]    hc;
  logic [VC_W-1:0]    vc;
  logic               mode_q;
  logic [1:0]         pat_q;
  logic               h_last;
  logic               v_last;
  int                 hx;
  int                 vy;
  int                 bar;
  int                 step;
  int                 level;
  logic [2:0]         bar_idx;
  logic               grid_full;
  logic               grid_mid;
  logic               hb_nx;
  logic               hs_nx;
  logic               vb_nx;
  logic               vs_nx;
  logic [COLOR_W-1:0] pr;
  logic [COLOR_W-1:0] pg;
  logic [COLOR_W-1:0] pb;

  always_ff @(posedge clk) begin
    if (reset) begin
      div    <= '0;
      ce_pix <= 1'b0;
    end else if (div == DIV_W'(CE_DIV - 1)) begin
      div    <= '0;
      ce_pix <= 1'b1;
    end else begin
      div    <= div + 1'b1;
      ce_pix <= 1'b0;
    end
  end

  assign h_last = (hc == HC_W'(H_TOTAL - 1));
  assign v_last = (vc == (mode_q ? VC_W'(V_TOTAL_PAL - 1) : VC_W'(V_TOTAL_NTSC - 1)));

  // Mode and pattern are only sampled on the final pixel so every frame is uniform.
  always_ff @(posedge clk) begin
    if (reset) begin
      hc     <= '0;
      vc     <= '0;
      mode_q <= 1'b0;
      pat_q  <= 2'd0;
    end else if (ce_pix) begin
      if (h_last) begin
        hc <= '0;
        if (v_last) begin
          vc     <= '0;
          mode_q <= pal;
          pat_q  <= pattern_sel;
        end else begin
          vc <= vc + 1'b1;
        end
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  always_comb begin
    hx      = int'(hc);
    vy      = int'(vc);
    bar     = hx / (H_ACTIVE / 8);
    step    = hx / (H_ACTIVE / 16);
    level   = (step * FULL) / 15;
    bar_idx = 3'(bar);
    grid_full = (hx == 0) || (hx == H_ACTIVE - 1) || (vy == 0) || (vy == V_ACTIVE - 1) ||
                (hx == H_ACTIVE / 2 - 1) || (hx == H_ACTIVE / 2) ||
                (vy == V_ACTIVE / 2 - 1) || (vy == V_ACTIVE / 2) ||
                (((hx == BOX_X0) || (hx == BOX_X1)) && (vy >= BOX_Y0) && (vy <= BOX_Y1)) ||
                (((vy == BOX_Y0) || (vy == BOX_Y1)) && (hx >= BOX_X0) && (hx <= BOX_X1));
    grid_mid  = (((hx == SAFE_X0) || (hx == SAFE_X1)) && (vy >= SAFE_Y0) && (vy <= SAFE_Y1)) ||
                (((vy == SAFE_Y0) || (vy == SAFE_Y1)) && (hx >= SAFE_X0) && (hx <= SAFE_X1));
    hb_nx = (hx >= H_ACTIVE);
    hs_nx = !((hx >= H_ACTIVE + H_FP) && (hx < H_ACTIVE + H_FP + H_SYNC));
    vb_nx = (vy >= V_ACTIVE);
    vs_nx = (vy >= V_ACTIVE + V_FP) && (vy < V_ACTIVE + V_FP + V_SYNC);
    pr = '0;
    pg = '0;
    pb = '0;
    case (pat_q)
      2'd0: begin
        pr = grid_full ? COLOR_W'(FULL) : (grid_mid ? COLOR_W'(MID) : COLOR_W'(GRID_BG));
        pg = pr;
        pb = pr;
      end
      // Bar order white..black maps onto inverted index bits.
      2'd1: begin
        pr = {COLOR_W{~bar_idx[1]}};
        pg = {COLOR_W{~bar_idx[2]}};
        pb = {COLOR_W{~bar_idx[0]}};
      end
      2'd2: begin
        pr = COLOR_W'(level);
        pg = pr;
        pb = pr;
      end
      default: begin
        pr = {COLOR_W{hc[0] ^ vc[0]}};
        pg = pr;
        pb = pr;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hblank      <= 1'b0;
      hsync       <= 1'b1;
      vblank      <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else begin
      frame_start <= ce_pix && (hc == '0) && (vc == '0);
      if (ce_pix) begin
        hblank <= hb_nx;
        hsync  <= hs_nx;
        vblank <= vb_nx;
        vsync  <= vs_nx;
        r      <= (hb_nx || vb_nx) ? '0 : pr;
        g      <= (hb_nx || vb_nx) ? '0 : pg;
        b      <= (hb_nx || vb_nx) ? '0 : pb;
      end
    end
  end
endmodule
